// File: rtl/fp_int_acc_seq_pkg.sv
// Shared definitions for the FP-to-integer accumulation sequencer and the
// external accumulator it drives.
//   - EXP_W / FRAC_W / ACC_W : default exponent, operand magnitude and
//     running-sum widths.
//   - seq_state_e            : sequencer FSM state encoding.
package fp_int_acc_seq_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 14;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fp_int_acc_seq_cnt.sv
// Element and latency counters for the accumulation sequencer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   elem_inc_i    : count one accepted element
//   elem_clr_i    : clear element count (vector delivered)
//   lat_clr_i     : restart the accumulator latency count
//   lat_inc_i     : advance the latency count
//   elem_cnt_o    : elements accepted in the current vector
//   elem_full_o   : element count has reached VEC_LEN
//   lat_done_o    : current cycle is the last accumulator wait cycle
module fp_int_acc_seq_cnt #(
  parameter int VEC_LEN = 16,
  parameter int ACC_LAT = 2,
  parameter int CNT_W   = $clog2(VEC_LEN) + 1,
  parameter int LAT_W   = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             elem_inc_i,
  input  logic             elem_clr_i,
  input  logic             lat_clr_i,
  input  logic             lat_inc_i,
  output logic [CNT_W-1:0] elem_cnt_o,
  output logic             elem_full_o,
  output logic             lat_done_o
);

  logic [CNT_W-1:0] elem_q;
  logic [LAT_W-1:0] lat_q;

  assign elem_full_o = (elem_q == CNT_W'(VEC_LEN));
  assign lat_done_o  = (lat_q == LAT_W'(ACC_LAT - 1));
  assign elem_cnt_o  = elem_q;

  // The element count saturates at VEC_LEN; the sequencer closes the
  // vector there, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (rst || elem_clr_i) begin
      elem_q <= '0;
    end else if (elem_inc_i && !elem_full_o) begin
      elem_q <= elem_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || lat_clr_i) begin
      lat_q <= '0;
    end else if (lat_inc_i && !lat_done_o) begin
      lat_q <= lat_q + 1'b1;
    end
  end

endmodule

// File: rtl/fp_int_acc_seq.sv
// Sequencer that feeds product terms, one at a time, into an external
// fixed-point accumulator and returns one result per vector.  It only
// registers and routes values; all alignment/add arithmetic lives in the
// accumulator.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid/data must be held until that edge; ready may depend on
// state only, never on valid.  in_ready and out_valid are never high
// together.
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid / in_ready              : operand handshake
//   in_sign, in_exp, in_frac, in_last: operand and end-of-vector marker
//   acc_start                        : one-cycle accumulator start pulse
//   acc_sign, acc_exp_in, acc_fixed_in: operand to accumulator
//   acc_exp_min, acc_fixed_acc       : running exponent / sum fed back
//   acc_exp_out, acc_fixed_out       : accumulator result
//   out_valid / out_ready            : result handshake
//   out_exp, out_fixed, out_trunc    : vector result, closed-by-limit flag
//   busy                             : high outside ACCEPT
//   state_dbg_o                      : current FSM state
module fp_int_acc_seq
  import fp_int_acc_seq_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ACC_LAT = 2,
  parameter int EXP_W   = fp_int_acc_seq_pkg::EXP_W,
  parameter int FRAC_W  = fp_int_acc_seq_pkg::FRAC_W,
  parameter int ACC_W   = fp_int_acc_seq_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_last,
  output logic              acc_start,
  output logic              acc_sign,
  output logic [EXP_W-1:0]  acc_exp_in,
  output logic [FRAC_W-1:0] acc_fixed_in,
  output logic [EXP_W-1:0]  acc_exp_min,
  output logic [ACC_W-1:0]  acc_fixed_acc,
  input  logic [EXP_W-1:0]  acc_exp_out,
  input  logic [ACC_W-1:0]  acc_fixed_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  out_exp,
  output logic [ACC_W-1:0]  out_fixed,
  output logic              out_trunc,
  output logic              busy,
  output seq_state_e        state_dbg_o
);

  localparam int CNT_W = $clog2(VEC_LEN) + 1;

  seq_state_e        state_q;
  logic              first_q;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [FRAC_W-1:0] frac_q;
  logic              last_q;
  logic [EXP_W-1:0]  run_exp_q;
  logic [ACC_W-1:0]  run_fixed_q;
  logic              trunc_q;

  logic              elem_full;
  logic              lat_done;
  logic [CNT_W-1:0]  elem_cnt;
  logic              accept;
  logic              out_fire;

  assign accept   = (state_q == ST_ACCEPT) && in_valid;
  assign out_fire = (state_q == ST_OUT) && out_ready;

  fp_int_acc_seq_cnt #(
    .VEC_LEN (VEC_LEN),
    .ACC_LAT (ACC_LAT),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .elem_inc_i  (accept),
    .elem_clr_i  (out_fire),
    .lat_clr_i   (state_q == ST_ISSUE),
    .lat_inc_i   (state_q == ST_WAIT),
    .elem_cnt_o  (elem_cnt),
    .elem_full_o (elem_full),
    .lat_done_o  (lat_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      first_q     <= 1'b1;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      last_q      <= 1'b0;
      run_exp_q   <= '0;
      run_fixed_q <= '0;
      trunc_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= in_exp;
            frac_q  <= in_frac;
            last_q  <= in_last;
            // A new vector starts from an empty sum at the element's own
            // exponent, so the accumulator's alignment is a no-op for it.
            if (first_q) begin
              run_exp_q   <= in_exp;
              run_fixed_q <= '0;
            end
            first_q <= 1'b0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_done) begin
            run_exp_q   <= acc_exp_out;
            run_fixed_q <= acc_fixed_out;
            // elem_cnt already includes the element just accumulated.
            if (last_q || elem_full) begin
              trunc_q <= elem_full && !last_q;
              state_q <= ST_OUT;
            end else begin
              state_q <= ST_ACCEPT;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            first_q <= 1'b1;
            trunc_q <= 1'b0;
            state_q <= ST_ACCEPT;
          end
        end
        default: state_q <= ST_ACCEPT;
      endcase
    end
  end

  // All outputs are decoded straight from registers.  Operand and feedback
  // registers only change on acceptance and on capture, so they are stable
  // from ISSUE through the final WAIT cycle.
  assign in_ready      = (state_q == ST_ACCEPT);
  assign busy          = (state_q != ST_ACCEPT);
  assign acc_start     = (state_q == ST_ISSUE);
  assign out_valid     = (state_q == ST_OUT);
  assign acc_sign      = sign_q;
  assign acc_exp_in    = exp_q;
  assign acc_fixed_in  = frac_q;
  assign acc_exp_min   = run_exp_q;
  assign acc_fixed_acc = run_fixed_q;
  assign out_exp       = run_exp_q;
  assign out_fixed     = run_fixed_q;
  assign out_trunc     = trunc_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_fp_int_acc_seq.sv
module tb_fp_int_acc_seq;
  import fp_int_acc_seq_pkg::*;

  localparam int VEC_LEN = 4;
  localparam int ACC_LAT = 2;
  localparam int EW = 5;
  localparam int FW = 14;
  localparam int AW = 32;
  localparam int NV = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [EW-1:0] in_exp = '0;
  logic [FW-1:0] in_frac = '0;
  logic          in_last = 1'b0;
  logic          acc_start;
  logic          acc_sign;
  logic [EW-1:0] acc_exp_in;
  logic [FW-1:0] acc_fixed_in;
  logic [EW-1:0] acc_exp_min;
  logic [AW-1:0] acc_fixed_acc;
  logic [EW-1:0] acc_exp_out;
  logic [AW-1:0] acc_fixed_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [EW-1:0] out_exp;
  logic [AW-1:0] out_fixed;
  logic          out_trunc;
  logic          busy;
  seq_state_e    state_dbg;

  fp_int_acc_seq #(.VEC_LEN(VEC_LEN), .ACC_LAT(ACC_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_last(in_last),
    .acc_start(acc_start), .acc_sign(acc_sign), .acc_exp_in(acc_exp_in),
    .acc_fixed_in(acc_fixed_in), .acc_exp_min(acc_exp_min),
    .acc_fixed_acc(acc_fixed_acc), .acc_exp_out(acc_exp_out),
    .acc_fixed_out(acc_fixed_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_fixed(out_fixed), .out_trunc(out_trunc),
    .busy(busy), .state_dbg_o(state_dbg)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accumulator arithmetic: align both terms to the smaller exponent,
  // then add or subtract the operand.  Returns {exp, sum}.
  function automatic logic [36:0] acc_f(input logic [4:0] rexp, input logic [31:0] rfix,
                                        input logic s, input logic [4:0] e, input logic [13:0] f);
    logic [4:0] m;
    logic signed [31:0] a;
    logic signed [31:0] b;
    m = (e < rexp) ? e : rexp;
    a = $signed(rfix) <<< (rexp - m);
    b = $signed({18'd0, f}) <<< (e - m);
    return {m, s ? (a - b) : (a + b)};
  endfunction

  // Accumulator model: result is presented only during the last wait
  // cycle; any other time the outputs carry a recognisable junk pattern.
  logic [EW-1:0] m_exp;
  logic [AW-1:0] m_fix;
  int            m_age;
  always @(posedge clk) begin
    if (rst) begin
      m_age <= 0;
    end else if (acc_start) begin
      {m_exp, m_fix} <= acc_f(acc_exp_min, acc_fixed_acc, acc_sign, acc_exp_in, acc_fixed_in);
      m_age <= 1;
    end else if (m_age != 0 && m_age < 100) begin
      m_age <= m_age + 1;
    end
  end
  assign acc_exp_out   = (m_age == ACC_LAT) ? m_exp : 5'h15;
  assign acc_fixed_out = (m_age == ACC_LAT) ? m_fix : 32'hDEAD_BEEF;

  // Handshake exclusivity, checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) chk("ready_valid_excl", 32'(in_ready && out_valid), 32'd0);
  end

  // ---------------- scoreboard state ----------------
  logic [31:0]   exp_q[$];
  logic [EW-1:0] ref_exp;
  logic [AW-1:0] ref_fixed;
  bit            tb_first;
  int            tb_cnt;

  // ---------------- driver tasks ----------------
  task automatic send_elem(input logic s, input logic [4:0] e, input logic [13:0] f,
                           input logic l, input int gap, output logic closed);
    int n;
    logic [4:0]  x_emin;
    logic [31:0] x_facc;
    repeat (gap) @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f; in_last = l;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sign = 1'($urandom); in_exp = 5'($urandom); in_frac = 14'($urandom); in_last = 1'($urandom);
    x_emin = tb_first ? e : ref_exp;
    x_facc = tb_first ? 32'd0 : ref_fixed;
    chk("issue_start", 32'(acc_start), 32'd1);
    chk("issue_ready", 32'(in_ready), 32'd0);
    chk("issue_busy", 32'(busy), 32'd1);
    for (int k = 0; k <= ACC_LAT; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("wait_start", 32'(acc_start), 32'd0);
        chk("wait_ready", 32'(in_ready), 32'd0);
        chk("wait_outv", 32'(out_valid), 32'd0);
      end
      chk("acc_sign", 32'(acc_sign), 32'(s));
      chk("acc_exp_in", 32'(acc_exp_in), 32'(e));
      chk("acc_fixed_in", 32'(acc_fixed_in), 32'(f));
      chk("acc_exp_min", 32'(acc_exp_min), 32'(x_emin));
      chk("acc_fixed_acc", acc_fixed_acc, x_facc);
    end
    {ref_exp, ref_fixed} = acc_f(x_emin, x_facc, s, e, f);
    tb_cnt++;
    tb_first = 1'b0;
    closed = l || (tb_cnt == VEC_LEN);
    @(negedge clk);
    chk("post_outv", 32'(out_valid), 32'(closed));
    chk("post_ready", 32'(in_ready), 32'(!closed));
  endtask

  task automatic check_out(input logic [4:0] x_exp, input logic [31:0] x_fixed,
                           input logic x_trunc, input int hold);
    logic [31:0] want;
    exp_q.push_back(x_fixed);
    want = exp_q.pop_front();
    chk("out_exp", 32'(out_exp), 32'(x_exp));
    chk("out_fixed", out_fixed, want);
    chk("out_trunc", 32'(out_trunc), 32'(x_trunc));
    chk("out_busy", 32'(busy), 32'd1);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_exp = 5'($urandom);
      @(negedge clk);
      chk("hold_outv", 32'(out_valid), 32'd1);
      chk("hold_exp", 32'(out_exp), 32'(x_exp));
      chk("hold_fixed", out_fixed, want);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_start", 32'(acc_start), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_outv", 32'(out_valid), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_trunc", 32'(out_trunc), 32'd0);
    tb_first = 1'b1;
    tb_cnt = 0;
  endtask

  typedef struct {
    logic        s;
    logic [4:0]  e;
    logic [13:0] f;
    logic        l;
    logic        rgap;
    int          hold;
    logic [4:0]  x_exp;
    logic [31:0] x_fixed;
    logic        x_trunc;
  } vec_t;

  vec_t tbl[NV];

  initial begin
    logic closed;
    // single element
    tbl[0]  = '{1'b0, 5'd10, 14'h0100, 1'b1, 1'b0, 0, 5'd10, 32'd256, 1'b0};
    // four elements, mixed signs and exponents
    tbl[1]  = '{1'b0, 5'd10, 14'h0100, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[2]  = '{1'b1, 5'd12, 14'h0080, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[3]  = '{1'b0, 5'd8,  14'h0200, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[4]  = '{1'b1, 5'd8,  14'h0040, 1'b1, 1'b0, 0, 5'd8, 32'hFFFF_FDC0, 1'b0};
    // no in_last: closed by the VEC_LEN limit twice
    tbl[5]  = '{1'b0, 5'd4,  14'h0010, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[6]  = '{1'b0, 5'd4,  14'h0020, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[7]  = '{1'b1, 5'd5,  14'h0008, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[8]  = '{1'b0, 5'd3,  14'h0004, 1'b0, 1'b0, 0, 5'd3, 32'd68, 1'b1};
    tbl[9]  = '{1'b0, 5'd7,  14'h0100, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[10] = '{1'b0, 5'd7,  14'h0100, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[11] = '{1'b0, 5'd6,  14'h0001, 1'b0, 1'b0, 0, 5'd0, 32'd0, 1'b0};
    tbl[12] = '{1'b1, 5'd6,  14'h0002, 1'b0, 1'b0, 0, 5'd6, 32'd1023, 1'b1};
    // out_ready withheld for 10 cycles
    tbl[13] = '{1'b1, 5'd0,  14'h3FFF, 1'b1, 1'b0, 10, 5'd0, 32'hFFFF_C001, 1'b0};
    // largest exponent and magnitude
    tbl[14] = '{1'b0, 5'd31, 14'h3FFF, 1'b1, 1'b0, 0, 5'd31, 32'h0000_3FFF, 1'b0};
    // same four-element vector with random input gaps
    tbl[15] = '{1'b0, 5'd10, 14'h0100, 1'b0, 1'b1, 0, 5'd0, 32'd0, 1'b0};
    tbl[16] = '{1'b1, 5'd12, 14'h0080, 1'b0, 1'b1, 0, 5'd0, 32'd0, 1'b0};
    tbl[17] = '{1'b0, 5'd8,  14'h0200, 1'b0, 1'b1, 0, 5'd0, 32'd0, 1'b0};
    tbl[18] = '{1'b1, 5'd8,  14'h0040, 1'b1, 1'b1, 0, 5'd8, 32'hFFFF_FDC0, 1'b0};

    tb_first = 1'b1;
    tb_cnt = 0;
    ref_exp = '0;
    ref_fixed = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(acc_start), 32'd0);
    chk("rst_outv", 32'(out_valid), 32'd0);
    chk("rst_trunc", 32'(out_trunc), 32'd0);
    chk("rst_out_fixed", out_fixed, 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_acc_fixed_acc", acc_fixed_acc, 32'd0);
    chk("rst_acc_fixed_in", 32'(acc_fixed_in), 32'd0);

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      send_elem(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].l,
                tbl[i].rgap ? int'($urandom_range(0, 5)) : 0, closed);
      if (closed) check_out(tbl[i].x_exp, tbl[i].x_fixed, tbl[i].x_trunc, tbl[i].hold);
    end

    // reset during the wait of the third element
    for (int i = 1; i <= 2; i++) send_elem(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].l, 0, closed);
    chk("pre_rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 5'd8; in_frac = 14'h0200; in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_issue", 32'(acc_start), 32'd1);
    @(negedge clk);
    chk("pre_rst_wait", {30'd0, state_dbg}, {30'd0, ST_WAIT});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", {30'd0, state_dbg}, {30'd0, ST_ACCEPT});
    chk("mid_rst_start", 32'(acc_start), 32'd0);
    chk("mid_rst_outv", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fixed_acc", acc_fixed_acc, 32'd0);
    chk("mid_rst_out_fixed", out_fixed, 32'd0);
    chk("mid_rst_exp_min", 32'(acc_exp_min), 32'd0);
    rst = 1'b0;
    tb_first = 1'b1;
    tb_cnt = 0;
    repeat (ACC_LAT + 2) begin
      @(negedge clk);
      chk("post_rst_start", 32'(acc_start), 32'd0);
      chk("post_rst_outv", 32'(out_valid), 32'd0);
    end
    send_elem(tbl[0].s, tbl[0].e, tbl[0].f, tbl[0].l, 0, closed);
    chk("post_rst_closed", 32'(closed), 32'd1);
    check_out(5'd10, 32'd256, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_int_acc_seq.md
FP_INT_ACC_SEQ -- requirements
Module: fp_int_acc_seq

Interface
REQ-001 Parameters: VEC_LEN, default 16, maximum products per vector; ACC_LAT, default 2, accumulator cycles from start to valid result; EXP_W, default 5; FRAC_W, default 14; ACC_W, default 32.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  product operand valid.
REQ-005 in_ready  output  1  sequencer accepts operand this cycle.
REQ-006 in_sign / in_exp / in_frac / in_last  input  1 / EXP_W / FRAC_W / 1  product sign, exponent, fixed-point magnitude, final element of vector.
REQ-007 acc_start  output  1  one-cycle start pulse to accumulator.
REQ-008 acc_sign / acc_exp_in / acc_fixed_in  output  1 / EXP_W / FRAC_W  operand to accumulator.
REQ-009 acc_exp_min / acc_fixed_acc  output  EXP_W / ACC_W  running exponent and running sum fed back to accumulator.
REQ-010 acc_exp_out / acc_fixed_out  input  EXP_W / ACC_W  accumulator result.
REQ-011 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 out_exp / out_fixed  output  EXP_W / ACC_W  vector result.
REQ-013 out_trunc  output  1  vector closed by VEC_LEN limit, not in_last.
REQ-014 busy  output  1  high in any state except ACCEPT.

Function
REQ-015 FSM states: ACCEPT, ISSUE, WAIT, OUT; encoded as shared enum.
REQ-016 ACCEPT: in_ready=1; on in_valid latch sign/exp/frac/last, increment element count, go ISSUE.
REQ-017 First element of a vector: run_exp loaded with in_exp, run_fixed loaded with 0 on acceptance.
REQ-018 ISSUE: acc_start=1 for exactly one cycle; acc_exp_min=run_exp, acc_fixed_acc=run_fixed; go WAIT.
REQ-019 acc_* operand and feedback outputs held stable from ISSUE through end of WAIT.
REQ-020 WAIT: count ACC_LAT cycles after ISSUE; on final count capture acc_exp_out into run_exp, acc_fixed_out into run_fixed.
REQ-021 After capture: if latched last or count==VEC_LEN go OUT, else go ACCEPT (next element, not first).
REQ-022 Issue-to-capture latency exactly ACC_LAT+1 cycles; element throughput one per ACC_LAT+2 cycles at full in_valid.
REQ-023 OUT: out_valid=1, out_exp=run_exp, out_fixed=run_fixed, out_trunc=(count==VEC_LEN and not last); hold until out_ready.
REQ-024 out_valid && out_ready: clear count, set first flag, go ACCEPT same edge; in_ready rises next cycle.
REQ-025 in_ready and out_valid never both high; in_valid ignored outside ACCEPT.
REQ-026 in_last on first element: single-element vector, result = accumulator output for that element.
REQ-027 Element count width clog2(VEC_LEN)+1; never wraps; count==VEC_LEN forces OUT even without in_last.
REQ-028 Arithmetic width rules belong to accumulator; sequencer performs no add/shift, only register and route.

Reset
REQ-029 rst high at any clock edge: state=ACCEPT, count=0, first flag=1, run_exp=0, run_fixed=0.
REQ-030 Reset values: acc_start=0, out_valid=0, out_trunc=0, busy=0, all data outputs 0; in_ready=1 first cycle after rst deasserts.
REQ-031 Reset mid-vector (ISSUE/WAIT/OUT) discards partial sum; no acc_start or out_valid emitted during or after reset edge.

Structure
REQ-032 Shared package holds FSM state enum and EXP_W/FRAC_W/ACC_W widths, reused by accumulator and sequencer.
REQ-033 Accumulator instanced outside; one optional sub-module fp_int_acc_seq_cnt (element + latency counters).

Verification
REQ-034 Single element: exp=10, frac=0x0100, sign=0, last=1 -> one acc_start, out_valid after ACC_LAT+2 cycles, out_fixed=model value, out_trunc=0.
REQ-035 Four elements (exps 10,12,8,8; mixed signs), in_valid constant -> acc_start every ACC_LAT+2 cycles, acc_fixed_acc equals previous acc_fixed_out, final out matches golden model.
REQ-036 VEC_LEN=4, six elements, no in_last -> out_trunc=1 after fourth; fifth element starts new vector with run_fixed=0.
REQ-037 out_ready held low 10 cycles -> out_valid/out_exp/out_fixed stable, in_ready=0 throughout, no acc_start.
REQ-038 rst asserted during WAIT of element 3 -> next cycle state ACCEPT, outputs 0; following vector result excludes pre-reset elements.
REQ-039 in_valid gaps of random 0-5 cycles -> results identical to gap-free run; acc_* stable through every WAIT.
